// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: boot address, the canonical NOP
// and the layout of one fetch queue entry.
package fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;
    localparam logic [31:0] NOP      = 32'h00000013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order imem reads at the PC stage's
// address, queues returned words for decode, and drops stale fetches on flush.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_advance,
    input  logic        flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    fetch_entry_t q_q [DEPTH];
    fetch_entry_t q_d [DEPTH];

    logic [PW-1:0] alloc_q, alloc_d;
    logic [PW-1:0] fill_q, fill_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] pend_q, pend_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic          fire;
    logic          deq;
    logic          rsp_fill;
    logic [CW:0]   busy;

    // Handshake outputs; request gating looks only at registered counters
    // so it can never combinationally depend on decode's ready.
    always_comb begin
        busy           = {1'b0, occ_q} + {1'b0, drop_cnt_q};
        imem_req_valid = !rst && !flush && (busy < DEPTH_C);
        imem_req_addr  = pc;
        fire           = imem_req_valid && imem_req_ready;
        pc_advance     = fire;
        instr_valid    = (occ_q != '0) && q_q[rd_q].filled;
        instr          = q_q[rd_q].instr;
        instr_pc       = q_q[rd_q].pc;
        deq            = instr_valid && instr_ready;
        rsp_fill       = imem_rsp_valid && (drop_cnt_q == '0);
    end

    // Queue, pointer and discard-counter updates; a flush wins over
    // everything and converts every unfilled entry into a pending drop.
    always_comb begin
        q_d        = q_q;
        alloc_d    = alloc_q;
        fill_d     = fill_q;
        rd_d       = rd_q;
        occ_d      = occ_q;
        pend_d     = pend_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            alloc_d    = '0;
            fill_d     = '0;
            rd_d       = '0;
            occ_d      = '0;
            pend_d     = '0;
            drop_cnt_d = drop_cnt_q + pend_q - CW'(imem_rsp_valid);
        end else begin
            if (fire) begin
                q_d[alloc_q].pc     = pc;
                q_d[alloc_q].instr  = '0;
                q_d[alloc_q].filled = 1'b0;
                alloc_d             = alloc_q + 1'b1;
            end
            if (imem_rsp_valid && !rsp_fill) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (rsp_fill) begin
                q_d[fill_q].instr  = imem_rsp_data;
                q_d[fill_q].filled = 1'b1;
                fill_d             = fill_q + 1'b1;
            end
            if (deq) begin
                rd_d = rd_q + 1'b1;
            end
            occ_d  = occ_q + CW'(fire) - CW'(deq);
            pend_d = pend_q + CW'(fire) - CW'(rsp_fill);
        end
    end

    // State registers with asynchronous reset shared with instruction memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= '0;
            end
            alloc_q    <= '0;
            fill_q     <= '0;
            rd_q       <= '0;
            occ_q      <= '0;
            pend_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            q_q        <= q_d;
            alloc_q    <= alloc_d;
            fill_q     <= fill_d;
            rd_q       <= rd_d;
            occ_q      <= occ_d;
            pend_q     <= pend_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural PC stage and a
// fixed-latency in-order instruction memory.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = RESET_PC;
    logic        pc_advance;
    logic        flush = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int lat = 1;
    logic [31:0] redirect = '0;

    fetch_unit #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_advance(pc_advance),
        .flush(flush), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        case (a)
            RESET_PC:          return 32'h00000013;
            RESET_PC + 32'd4:  return 32'h00500093;
            RESET_PC + 32'd8:  return 32'h00A00113;
            default:           return {a[15:0], 16'h0113};
        endcase
    endfunction

    typedef struct {
        logic [31:0] a;
        int          cnt;
    } mreq_t;

    mreq_t       mq[$];
    logic        fire_s = 1'b0;
    logic        flush_s = 1'b0;
    logic [31:0] addr_s = '0;

    // Sample the cycle's handshakes once everything has settled.
    always @(negedge clk) begin
        fire_s  = imem_req_valid & imem_req_ready;
        addr_s  = imem_req_addr;
        flush_s = flush;
    end

    // Memory and PC-stage model, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            mq.delete();
            pc = RESET_PC;
            imem_rsp_valid = 1'b0;
            imem_rsp_data = '0;
        end else begin
            foreach (mq[i]) mq[i].cnt = mq[i].cnt - 1;
            if (fire_s) mq.push_back('{addr_s, lat});
            imem_rsp_valid = 1'b0;
            imem_rsp_data = '0;
            if (mq.size() > 0 && mq[0].cnt <= 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = memw(mq[0].a);
                void'(mq.pop_front());
            end
            if (flush_s) pc = redirect;
            else if (fire_s) pc = pc + 32'd4;
        end
    end

    logic [31:0] rx_pc[$];
    logic [31:0] rx_in[$];
    int          rx_cyc[$];

    // Decode-side scoreboard of every completed handshake.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready) begin
            rx_pc.push_back(instr_pc);
            rx_in.push_back(instr);
            rx_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        flush = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        rx_pc.delete();
        rx_in.delete();
        rx_cyc.delete();
    endtask

    typedef struct {
        logic       rdy;
        logic       rv;
        logic       adv;
        logic [7:0] a;
        logic       iv;
        logic [7:0] p;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic rv,
                                input logic adv, input logic [7:0] a,
                                input logic iv, input logic [7:0] p);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.adv = adv;
        v.a = a; v.iv = iv; v.p = p;
        return v;
    endfunction

    vec_t        tbl [11];
    logic [31:0] exp_w [3];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(0, 1, 1, 8'h00, 0, 8'h00);
        tbl[1]  = mk(0, 1, 1, 8'h04, 0, 8'h00);
        tbl[2]  = mk(0, 1, 1, 8'h08, 1, 8'h00);
        tbl[3]  = mk(0, 1, 1, 8'h0C, 1, 8'h00);
        tbl[4]  = mk(0, 0, 0, 8'h10, 1, 8'h00);
        tbl[5]  = mk(1, 0, 0, 8'h10, 1, 8'h00);
        tbl[6]  = mk(1, 1, 1, 8'h10, 1, 8'h04);
        tbl[7]  = mk(1, 1, 1, 8'h14, 1, 8'h08);
        tbl[8]  = mk(1, 1, 1, 8'h18, 1, 8'h0C);
        tbl[9]  = mk(1, 1, 1, 8'h1C, 1, 8'h10);
        tbl[10] = mk(1, 1, 1, 8'h20, 1, 8'h14);
        exp_w[0] = 32'h00000013;
        exp_w[1] = 32'h00500093;
        exp_w[2] = 32'h00A00113;

        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_instr_valid", instr_valid, 0);
            chk("rst_pc_advance", pc_advance, 0);
            chk("rst_instr", instr, 0);
            chk("rst_instr_pc", instr_pc, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        // Backpressure then release, straight out of reset.
        for (int i = 0; i < 11; i++) begin
            instr_ready = tbl[i].rdy;
            @(negedge clk);
            chk("bp_req_valid", imem_req_valid, tbl[i].rv);
            chk("bp_pc_advance", pc_advance, tbl[i].adv);
            chk("bp_req_addr", imem_req_addr, RESET_PC + 32'(tbl[i].a));
            chk("bp_instr_valid", instr_valid, tbl[i].iv);
            if (tbl[i].iv) begin
                chk("bp_instr_pc", instr_pc, RESET_PC + 32'(tbl[i].p));
                chk("bp_instr", instr, memw(RESET_PC + 32'(tbl[i].p)));
            end
            next();
        end

        // Streaming with a one-cycle memory.
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            next();
        end
        chk("stream_count", 32'(rx_pc.size() >= 3), 1);
        if (rx_pc.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("stream_pc", rx_pc[i], RESET_PC + 32'(4 * i));
                chk("stream_instr", rx_in[i], exp_w[i]);
                chk("stream_cycle", 32'(rx_cyc[i]), 32'(2 + i));
            end
        end

        // Flush with two fetches outstanding on a three-cycle memory.
        do_reset();
        lat = 3;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        redirect = RESET_PC + 32'h100;
        for (int c = 0; c < 9; c++) begin
            flush = (c == 2);
            @(negedge clk);
            if (c == 2) begin
                chk("fl_req_valid", imem_req_valid, 0);
                chk("fl_pc_advance", pc_advance, 0);
            end
            if (c == 3) begin
                chk("fl_redir_valid", imem_req_valid, 1);
                chk("fl_redir_addr", imem_req_addr, RESET_PC + 32'h100);
            end
            if (c >= 3 && c <= 6) chk("fl_stale_iv", instr_valid, 0);
            if (c == 7) begin
                chk("fl_first_iv", instr_valid, 1);
                chk("fl_first_pc", instr_pc, RESET_PC + 32'h100);
                chk("fl_first_instr", instr, memw(RESET_PC + 32'h100));
            end
            if (c == 8) chk("fl_second_pc", instr_pc, RESET_PC + 32'h104);
            next();
        end
        flush = 1'b0;
        chk("fl_rx_count", 32'(rx_pc.size() > 0), 1);
        if (rx_pc.size() > 0) chk("fl_rx_pc0", rx_pc[0], RESET_PC + 32'h100);

        // Flush coincident with a response and a ready memory.
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        redirect = RESET_PC + 32'h200;
        for (int c = 0; c < 5; c++) begin
            flush = (c == 1);
            @(negedge clk);
            if (c == 1) begin
                chk("co_rsp_present", imem_rsp_valid, 1);
                chk("co_req_valid", imem_req_valid, 0);
                chk("co_pc_advance", pc_advance, 0);
            end
            if (c == 2) begin
                chk("co_iv_next", instr_valid, 0);
                chk("co_req_addr", imem_req_addr, RESET_PC + 32'h200);
                chk("co_req_valid2", imem_req_valid, 1);
            end
            if (c == 3) chk("co_iv_c3", instr_valid, 0);
            if (c == 4) begin
                chk("co_iv_c4", instr_valid, 1);
                chk("co_instr_pc", instr_pc, RESET_PC + 32'h200);
                chk("co_instr", instr, memw(RESET_PC + 32'h200));
            end
            next();
        end
        flush = 1'b0;

        // Asynchronous reset with three entries queued.
        do_reset();
        lat = 1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            next();
        end
        @(negedge clk);
        chk("ar_iv_before", instr_valid, 1);
        chk("ar_rv_before", imem_req_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_iv_async", instr_valid, 0);
        chk("ar_rv_async", imem_req_valid, 0);
        chk("ar_adv_async", pc_advance, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("ar_restart_valid", imem_req_valid, 1);
        chk("ar_restart_addr", imem_req_addr, RESET_PC);
        next();
        @(negedge clk);
        next();
        @(negedge clk);
        chk("ar_first_iv", instr_valid, 1);
        chk("ar_first_pc", instr_pc, RESET_PC);
        chk("ar_first_instr", instr, 32'h00000013);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the PC stage and upstream of decode. Issues in-order word reads to instruction memory at the address the PC stage presents, tags each with its PC, and buffers returned instructions in a DEPTH-entry queue that decode drains with a valid/ready handshake. Tells the PC stage when to advance, and discards queued and in-flight fetches on a branch/JALR redirect.

## Interface
- DEPTH, 4, queue entries and maximum in-flight fetches; power of 2, ≥2
- RESET_PC, 32'hBFC00000, boot address; also taken from fetch_pkg
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- pc  in  32  current fetch address from PC stage
- pc_advance  out  1  PC stage moves to next address this cycle (request fired)
- flush  in  1  redirect (taken branch or JALR) this cycle
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  read address (= pc)
- imem_rsp_valid  in  1  read data returned, in request order, always accepted
- imem_rsp_data  in  32  instruction word
- instr_valid  out  1  head entry holds a filled instruction
- instr_ready  in  1  decode consumes head
- instr  out  32  head instruction
- instr_pc  out  32  PC of head instruction

## Operation
- Queue entry = {pc, instr, filled}. Three pointers: alloc, fill, read; occupancy = allocated entries.
- drop_cnt: stale in-flight responses still to discard, width $clog2(DEPTH+1).
- imem_req_valid = !rst & !flush & (occupancy + drop_cnt < DEPTH). Depends on registered state only, never on instr_ready.
- Request fire (valid & ready): allocate entry at alloc with pc, filled=0; pc_advance=1. Otherwise pc_advance=0; PC stage holds.
- Response: if drop_cnt>0, discard and decrement; else write data into entry at fill, set filled, advance fill.
- instr_valid = head entry allocated & filled. Dequeue on instr_valid & instr_ready; frees entry at that edge.
- Flush edge: all entries freed, pointers equalised; drop_cnt <= drop_cnt + unfilled_entries − imem_rsp_valid. Dequeue that cycle has no effect beyond the clear. Request suppressed during flush. PC stage loads the redirect target independently of pc_advance.
- No pc alignment checks; alignment belongs to the PC stage.
- Pointers wrap modulo DEPTH; full/empty distinguished by an occupancy counter.

## Timing
- Reset (async): occupancy 0, all pointers 0, drop_cnt 0, entry contents 0. Outputs: imem_req_valid 0, pc_advance 0, instr_valid 0, instr 0, instr_pc 0. First request is possible in the first cycle after rst deasserts.
- Latency: request fires in cycle N; memory with 1-cycle latency responds in N+1; instr_valid rises in N+2.
- No bypass. Space freed by a dequeue is usable for a request from the next cycle.
- Instruction memory shares rst. A response arriving after reset without a matching request is a protocol violation and is not handled.
- A simultaneous response and flush counts toward the discard, per the drop_cnt formula.
- Simultaneous fire, response and dequeue in one cycle: all three take effect; occupancy changes by +1−1.

## Structure
- fetch_pkg contains:
  - RESET_PC (shared with the PC stage)
  - NOP constant 32'h00000013
  - fetch_entry_t struct {logic [31:0] pc; logic [31:0] instr; logic filled;}
- Single module; no sub-module. The queue and drop logic are too tightly coupled to split.

## Test plan
- Reset: hold rst 3 cycles with pc=BFC00000, memory ready. No request and instr_valid=0 throughout. First cycle after release: imem_req_valid=1, addr BFC00000.
- Streaming: 1-cycle memory, instr_ready=1, PC stage stepping +4. Decode sees 00000013, 00500093, 00A00113 with instr_pc BFC00000/04/08, first at cycle 2, strictly in order.
- Backpressure: instr_ready=0, DEPTH=4. Exactly 4 requests fire, then imem_req_valid=0 and pc_advance=0. Release instr_ready: one dequeue per cycle, requests resume the cycle after the first dequeue.
- Flush with in-flight fetches: 3-cycle memory latency, flush with 2 fetches outstanding, PC redirected to BFC00100. Both stale responses are dropped. Next delivered entry is instr_pc BFC00100 with its data.
- Coincident events: flush in the same cycle as imem_rsp_valid and imem_req_ready. Response is discarded, no request fires, pc_advance=0, instr_valid=0 next cycle.
- Async reset mid-stream with 3 entries queued: instr_valid and imem_req_valid fall without a clock edge. Restart fetches from BFC00000.
